id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage core. It sits directly downstream of the register file. It latches the decoded instruction and both register-file read operands into the EX stage. It also patches operands with same-cycle writeback data, detects load-use hazards, and inserts bubbles. Its stall output freezes PC and IF/ID; its flush input squashes the instruction entering EX on a taken branch.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- ADDR_WIDTH, 5, register address width
- CTRL_WIDTH, 16, opaque decoded-control bundle width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc, id_imm  in  DATA_WIDTH  instruction PC, decoded immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  ADDR_WIDTH  register addresses, as presented to the register file read ports
- id_rs1_used, id_rs2_used  in  1  the instruction actually reads rs1 / rs2
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register file read data
- id_ctrl  in  CTRL_WIDTH  decoded control bundle
- id_mem_read, id_reg_write  in  1  instruction is a load / writes rd
- wb_write_en  in  1  writeback write strobe, same signal the register file receives
- wb_write_addr  in  ADDR_WIDTH  writeback destination
- wb_write_data  in  DATA_WIDTH  writeback value
- flush  in  1  taken branch/jump resolved in EX
- hold  in  1  downstream (MEM) stall request
- ex_valid, ex_mem_read, ex_reg_write  out  1  registered copies
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  DATA_WIDTH  registered
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  ADDR_WIDTH  registered
- ex_ctrl  out  CTRL_WIDTH  registered
- id_stall  out  1  combinational; freeze PC and IF/ID this cycle
- bubble_cnt  out  32  count of load-use bubbles inserted

## Operation
- Bypass (combinational):
  - op1 = wb_write_data when wb_write_en & wb_write_addr!=0 & wb_write_addr==id_rs1_addr; otherwise op1 = id_rs1_data.
  - op2 is formed the same way from id_rs2_addr and id_rs2_data.
  - Address 0 is never bypassed; x0 always reads 0.
- Load-use hazard: lu = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
- id_stall = hold | (lu & ~flush).
- Per-edge update, first matching rule wins:
  1. flush: bubble into EX.
  2. hold: EX registers keep their value. Held ex_rs1_data is refreshed from WB when wb_write_en & wb_write_addr!=0 & wb_write_addr==ex_rs1_addr. ex_rs2_data is refreshed the same way.
  3. lu: bubble into EX; bubble_cnt increments, saturating at 32'hFFFF_FFFF.
  4. otherwise: load all ex_* registers from id_* (operands from op1/op2). ex_valid=id_valid. ex_mem_read and ex_reg_write are gated by id_valid.
- Bubble: every ex_* output is cleared to 0, including ex_valid, ex_ctrl, ex_mem_read and ex_reg_write.
- A bubble or invalid slot never produces a hazard, because lu requires ex_valid.

## Timing
- Reset (rstn low, asynchronous): every ex_* output is 0 and bubble_cnt is 0. id_stall then reflects only hold, since ex_valid=0.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use hazard costs exactly one bubble:
  - Cycle N: id_stall=1.
  - Cycle N+1: EX shows the bubble, and ID still holds the dependent instruction.
  - lu is now 0 because ex_valid=0, so that instruction enters EX at edge N+1→N+2.
- Flush in the same cycle as lu: bubble inserted, id_stall low unless hold, bubble_cnt unchanged.
- Flush in the same cycle as hold: flush wins. EX is bubbled and id_stall=1 because hold is high.
- WB writing the register ID reads in the same cycle: EX captures wb_write_data, never the stale register-file value.
- Reset asserted mid-stall: outputs clear immediately. After release, the first edge loads ID normally.

## Test plan
- Basic load: id_valid=1, pc=0x100, rs1=3/data 0x11, rs2=4/data 0x22, rd=5 -> next cycle ex_pc=0x100, ex_rs1_data=0x11, ex_rs2_data=0x22, ex_rd_addr=5, ex_valid=1.
- Load-use: EX holds a load with rd=7; ID has rs2=7, rs2_used=1 -> id_stall=1 for one cycle, EX gets a bubble (all zero), bubble_cnt=1; the dependent instruction enters EX on the following edge.
- No false hazard: EX load rd=7, ID rs1=7 with rs1_used=0 -> no stall. EX load rd=0, ID rs1=0 -> no stall.
- WB bypass: id_rs1_addr=9, id_rs1_data=0xAAAA, wb_write_en=1, addr 9, data 0x1234 -> ex_rs1_data=0x1234. Repeat with addr 0 -> ex_rs1_data=0xAAAA.
- Hold with refresh: hold=1 for 3 cycles, ex_rs2_addr=6; a WB write of 0x55 to reg 6 in cycle 2 -> ex_rs2_data=0x55 and all other ex_* unchanged; id_stall=1 throughout.
- Flush priority and reset: flush=1 with hold=1 and lu=1 -> ex_valid=0, bubble_cnt unchanged. Drop rstn mid-sequence -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// hold/flush handling and a saturating bubble counter.
module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  id_valid,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [DATA_WIDTH-1:0] id_rs1_data,
    input  logic [DATA_WIDTH-1:0] id_rs2_data,
    input  logic [CTRL_WIDTH-1:0] id_ctrl,
    input  logic                  id_mem_read,
    input  logic                  id_reg_write,
    input  logic                  wb_write_en,
    input  logic [ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic                  flush,
    input  logic                  hold,
    output logic                  ex_valid,
    output logic                  ex_mem_read,
    output logic                  ex_reg_write,
    output logic [DATA_WIDTH-1:0] ex_pc,
    output logic [DATA_WIDTH-1:0] ex_imm,
    output logic [DATA_WIDTH-1:0] ex_rs1_data,
    output logic [DATA_WIDTH-1:0] ex_rs2_data,
    output logic [ADDR_WIDTH-1:0] ex_rs1_addr,
    output logic [ADDR_WIDTH-1:0] ex_rs2_addr,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr,
    output logic [CTRL_WIDTH-1:0] ex_ctrl,
    output logic                  id_stall,
    output logic [31:0]           bubble_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  reg_write;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] rs1_data;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [ADDR_WIDTH-1:0] rs1_addr;
        logic [ADDR_WIDTH-1:0] rs2_addr;
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [CTRL_WIDTH-1:0] ctrl;
    } ex_t;

    ex_t         ex_q, ex_d;
    logic [31:0] cnt_q, cnt_d;

    logic                  wb_live;
    logic                  id_hit1, id_hit2, ex_hit1, ex_hit2;
    logic [DATA_WIDTH-1:0] op1, op2;
    logic                  lu;

    // x0 is hardwired, so a writeback to it never forwards
    assign wb_live = wb_write_en && (wb_write_addr != '0);
    assign id_hit1 = wb_live && (wb_write_addr == id_rs1_addr);
    assign id_hit2 = wb_live && (wb_write_addr == id_rs2_addr);
    assign ex_hit1 = wb_live && (wb_write_addr == ex_q.rs1_addr);
    assign ex_hit2 = wb_live && (wb_write_addr == ex_q.rs2_addr);

    assign op1 = id_hit1 ? wb_write_data : id_rs1_data;
    assign op2 = id_hit2 ? wb_write_data : id_rs2_data;

    assign lu = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                id_valid &&
                ((id_rs1_used && (id_rs1_addr == ex_q.rd_addr)) ||
                 (id_rs2_used && (id_rs2_addr == ex_q.rd_addr)));

    assign id_stall = hold || (lu && !flush);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (hold) begin
            if (ex_hit1) ex_d.rs1_data = wb_write_data;
            if (ex_hit2) ex_d.rs2_data = wb_write_data;
        end else if (lu) begin
            ex_d = '0;
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.mem_read  = id_valid && id_mem_read;
            ex_d.reg_write = id_valid && id_reg_write;
            ex_d.pc        = id_pc;
            ex_d.imm       = id_imm;
            ex_d.rs1_data  = op1;
            ex_d.rs2_data  = op2;
            ex_d.rs1_addr  = id_rs1_addr;
            ex_d.rs2_addr  = id_rs2_addr;
            ex_d.rd_addr   = id_rd_addr;
            ex_d.ctrl      = id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_pc        = ex_q.pc;
    assign ex_imm       = ex_q.imm;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rs1_addr  = ex_q.rs1_addr;
    assign ex_rs2_addr  = ex_q.rs2_addr;
    assign ex_rd_addr   = ex_q.rd_addr;
    assign ex_ctrl      = ex_q.ctrl;
    assign bubble_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random
// traffic against a rule-level model of the EX latch contents.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_valid;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        id_rs1_used, id_rs2_used;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic [15:0] id_ctrl;
    logic        id_mem_read, id_reg_write;
    logic        wb_write_en;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic        flush, hold;
    logic        ex_valid, ex_mem_read, ex_reg_write;
    logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [15:0] ex_ctrl;
    logic        id_stall;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
        .id_reg_write(id_reg_write), .wb_write_en(wb_write_en),
        .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .ex_rd_addr(ex_rd_addr), .ex_ctrl(ex_ctrl),
        .id_stall(id_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Model of what EX should hold
    logic        m_valid, m_mr, m_rw;
    logic [31:0] m_pc, m_imm, m_r1, m_r2;
    logic [4:0]  m_a1, m_a2, m_rd;
    logic [15:0] m_ctrl;
    logic [31:0] m_cnt;

    function automatic logic [193:0] dut_vec();
        return {ex_valid, ex_mem_read, ex_reg_write, ex_pc, ex_imm,
                ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
                ex_rd_addr, ex_ctrl, bubble_cnt};
    endfunction

    function automatic logic [193:0] model_vec();
        return {m_valid, m_mr, m_rw, m_pc, m_imm, m_r1, m_r2,
                m_a1, m_a2, m_rd, m_ctrl, m_cnt};
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] d);
        if (wb_write_en && wb_write_addr != 0 && wb_write_addr == a)
            return wb_write_data;
        return d;
    endfunction

    function automatic logic model_lu();
        if (!m_valid || !m_mr || m_rd == 0 || !id_valid) return 1'b0;
        return (id_rs1_used && id_rs1_addr == m_rd) ||
               (id_rs2_used && id_rs2_addr == m_rd);
    endfunction

    function automatic logic model_stall();
        return hold || (model_lu() && !flush);
    endfunction

    task automatic model_clear_ex();
        {m_valid, m_mr, m_rw, m_pc, m_imm, m_r1, m_r2} = '0;
        {m_a1, m_a2, m_rd, m_ctrl} = '0;
    endtask

    task automatic model_edge();
        if (flush) begin
            model_clear_ex();
        end else if (hold) begin
            m_r1 = fwd(m_a1, m_r1);
            m_r2 = fwd(m_a2, m_r2);
        end else if (model_lu()) begin
            model_clear_ex();
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_mr = id_valid & id_mem_read;
            m_rw = id_valid & id_reg_write;
            m_pc = id_pc;
            m_imm = id_imm;
            m_r1 = fwd(id_rs1_addr, id_rs1_data);
            m_r2 = fwd(id_rs2_addr, id_rs2_data);
            m_a1 = id_rs1_addr;
            m_a2 = id_rs2_addr;
            m_rd = id_rd_addr;
            m_ctrl = id_ctrl;
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled there too
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_pc = 0; id_imm = 0; id_ctrl = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_used = 0; id_rs2_used = 0;
        id_rs1_data = 0; id_rs2_data = 0;
        id_mem_read = 0; id_reg_write = 0;
        wb_write_en = 0; wb_write_addr = 0; wb_write_data = 0;
        flush = 0; hold = 0;
    endtask

    task automatic apply_reset();
        rstn = 0;
        model_clear_ex();
        m_cnt = 0;
        #3;
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic put_load(logic [4:0] rd);
        idle();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1;
        id_rd_addr = rd; id_pc = 32'h40;
    endtask

    task automatic test_reset();
        idle();
        rstn = 0;
        #2;
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", dut_vec());
        end
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b want=0", id_stall);
        end
        hold = 1;
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold_stall got=%b want=1", id_stall);
        end
        idle();
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        idle();
        id_valid = 1; id_pc = 32'h100; id_imm = 32'h7;
        id_rs1_addr = 3; id_rs1_data = 32'h11; id_rs1_used = 1;
        id_rs2_addr = 4; id_rs2_data = 32'h22; id_rs2_used = 1;
        id_rd_addr = 5; id_reg_write = 1; id_ctrl = 16'hBEEF;
        tick();
        checks++;
        if (ex_pc !== 32'h100 || ex_rs1_data !== 32'h11 ||
            ex_rs2_data !== 32'h22 || ex_rd_addr !== 5 ||
            ex_valid !== 1 || ex_reg_write !== 1 || ex_ctrl !== 16'hBEEF) begin
            failures++;
            $display("FAIL basic_load got pc=%h r1=%h r2=%h rd=%0d v=%b want 100/11/22/5/1",
                     ex_pc, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_valid);
        end
        id_valid = 0; id_mem_read = 1; id_reg_write = 1;
        tick();
        checks++;
        if (ex_valid !== 0 || ex_mem_read !== 0 || ex_reg_write !== 0) begin
            failures++;
            $display("FAIL invalid_gating got v=%b mr=%b rw=%b want 0/0/0",
                     ex_valid, ex_mem_read, ex_reg_write);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        put_load(7);
        tick();
        idle();
        id_valid = 1; id_pc = 32'h44; id_rs2_addr = 7; id_rs2_used = 1;
        id_rs2_data = 32'h77; id_rd_addr = 8; id_reg_write = 1;
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall got=%b want=1", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 0 || ex_pc !== 0 || ex_rd_addr !== 0 ||
            ex_mem_read !== 0 || bubble_cnt !== 1) begin
            failures++;
            $display("FAIL lu_bubble got v=%b pc=%h cnt=%0d want 0/0/1",
                     ex_valid, ex_pc, bubble_cnt);
        end
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_release got=%b want=0", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 1 || ex_pc !== 32'h44 || ex_rs2_addr !== 7 ||
            bubble_cnt !== 1) begin
            failures++;
            $display("FAIL lu_enter got v=%b pc=%h rs2=%0d cnt=%0d want 1/44/7/1",
                     ex_valid, ex_pc, ex_rs2_addr, bubble_cnt);
        end
    endtask

    task automatic test_no_false_hazard();
        apply_reset();
        put_load(7);
        tick();
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rs1_used = 0;
        id_rs2_addr = 2; id_rs2_used = 1;
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL unused_rs1 got=%b want=0", id_stall);
        end
        put_load(0);
        tick();
        idle();
        id_valid = 1; id_rs1_addr = 0; id_rs1_used = 1;
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL rd_zero got=%b want=0", id_stall);
        end
    endtask

    task automatic test_bypass();
        apply_reset();
        idle();
        id_valid = 1; id_rs1_addr = 9; id_rs1_data = 32'hAAAA;
        id_rs1_used = 1; id_rs2_addr = 9; id_rs2_data = 32'hBBBB;
        wb_write_en = 1; wb_write_addr = 9; wb_write_data = 32'h1234;
        tick();
        checks++;
        if (ex_rs1_data !== 32'h1234 || ex_rs2_data !== 32'h1234) begin
            failures++;
            $display("FAIL bypass_hit got r1=%h r2=%h want 1234/1234",
                     ex_rs1_data, ex_rs2_data);
        end
        id_rs1_addr = 0; id_rs2_addr = 0; wb_write_addr = 0;
        tick();
        checks++;
        if (ex_rs1_data !== 32'hAAAA || ex_rs2_data !== 32'hBBBB) begin
            failures++;
            $display("FAIL bypass_x0 got r1=%h r2=%h want AAAA/BBBB",
                     ex_rs1_data, ex_rs2_data);
        end
    endtask

    task automatic test_hold_refresh();
        apply_reset();
        idle();
        id_valid = 1; id_pc = 32'h200; id_rs2_addr = 6;
        id_rs2_data = 32'h99; id_rs1_addr = 1; id_rs1_data = 32'h5;
        id_rd_addr = 2;
        tick();
        id_pc = 32'h204; id_rs2_addr = 3; id_rs2_data = 32'h1;
        hold = 1;
        for (int c = 1; c <= 3; c++) begin
            wb_write_en = (c == 2); wb_write_addr = 6;
            wb_write_data = 32'h55;
            #1;
            checks++;
            if (id_stall !== 1'b1) begin
                failures++;
                $display("FAIL hold_stall cyc=%0d got=%b want=1", c, id_stall);
            end
            tick();
            checks++;
            if (ex_pc !== 32'h200 || ex_rs1_data !== 32'h5 ||
                ex_rs2_addr !== 6 ||
                ex_rs2_data !== ((c >= 2) ? 32'h55 : 32'h99)) begin
                failures++;
                $display("FAIL hold_refresh cyc=%0d got pc=%h r2=%h", c,
                         ex_pc, ex_rs2_data);
            end
        end
    endtask

    task automatic test_flush_priority();
        apply_reset();
        put_load(7);
        tick();
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1;
        flush = 1; hold = 1;
        #1;
        checks++;
        if (id_stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_hold_stall got=%b want=1", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 0 || bubble_cnt !== 0 || ex_rd_addr !== 0) begin
            failures++;
            $display("FAIL flush_hold got v=%b cnt=%0d want 0/0",
                     ex_valid, bubble_cnt);
        end
        put_load(7);
        tick();
        idle();
        id_valid = 1; id_rs1_addr = 7; id_rs1_used = 1; flush = 1;
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_lu_stall got=%b want=0", id_stall);
        end
        tick();
        checks++;
        if (ex_valid !== 0 || bubble_cnt !== 0) begin
            failures++;
            $display("FAIL flush_lu got v=%b cnt=%0d want 0/0",
                     ex_valid, bubble_cnt);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        put_load(7);
        tick();
        idle();
        id_valid = 1; id_pc = 32'h88; id_rs2_addr = 7; id_rs2_used = 1;
        #2;
        rstn = 0;
        model_clear_ex();
        m_cnt = 0;
        #1;
        checks++;
        if (dut_vec() !== '0 || id_stall !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h stall=%b want 0", dut_vec(),
                     id_stall);
        end
        #2;
        rstn = 1;
        @(posedge clk);
        #1;
        model_clear_ex();
        tick();
        checks++;
        if (ex_valid !== 1 || ex_pc !== 32'h88 || bubble_cnt !== 0) begin
            failures++;
            $display("FAIL post_reset_load got v=%b pc=%h cnt=%0d want 1/88/0",
                     ex_valid, ex_pc, bubble_cnt);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            id_valid = ($urandom_range(0, 9) != 0);
            id_pc = $urandom; id_imm = $urandom; id_ctrl = 16'($urandom);
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            id_rd_addr = 5'($urandom_range(0, 7));
            id_rs1_used = $urandom_range(0, 1) != 0;
            id_rs2_used = $urandom_range(0, 1) != 0;
            id_rs1_data = $urandom; id_rs2_data = $urandom;
            id_mem_read = ($urandom_range(0, 2) == 0);
            id_reg_write = $urandom_range(0, 1) != 0;
            wb_write_en = $urandom_range(0, 1) != 0;
            wb_write_addr = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 6) == 0);
            #1;
            checks++;
            if (id_stall !== model_stall()) begin
                failures++;
                $display("FAIL rand_stall n=%0d got=%b want=%b", n, id_stall,
                         model_stall());
            end
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                failures++;
                $display("FAIL rand_state n=%0d got=%h want=%h", n, dut_vec(),
                         model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_use();
        test_no_false_hazard();
        test_bypass();
        test_hold_refresh();
        test_flush_priority();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
